// File: rtl/xor_cipher_cfg_ctrl.sv
// xor_cipher_cfg_ctrl
//   Sequencer for the dual XOR stream cipher. It accepts a key over a
//   valid/ready handshake and shifts it MSB-first into the cipher's serial
//   configuration chain (LOAD). It then shifts the same key a second time and
//   compares the bits that return from the chain (VERIFY). A clean verify
//   lands in RUN, where the tx/rx enables follow the requesters. Any mismatch
//   lands in ERR, where the enables are held off.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   key_valid/key_ready   key handshake; key_data[M-1] is shifted first
//   tx_req, rx_req        requests for the cipher TX/RX paths (honoured in RUN)
//   cfg_en, cfg_do        chain shift enable and serial data into the chain
//   cfg_di                serial data returning from the end of the chain
//   tx_en, rx_en          registered cipher enables
//   busy                  LOAD or VERIFY in progress
//   key_ok, err           last load verified (RUN) / failed (ERR)
//   mism_cnt              saturating count of mismatched bits in last VERIFY
module xor_cipher_cfg_ctrl #(
  parameter int M  = 32,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [M-1:0]  key_data,
  input  logic          tx_req,
  input  logic          rx_req,
  output logic          cfg_en,
  output logic          cfg_do,
  input  logic          cfg_di,
  output logic          tx_en,
  output logic          rx_en,
  output logic          busy,
  output logic          key_ok,
  output logic          err,
  output logic [CW-1:0] mism_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_VERIFY,
    S_RUN,
    S_ERR
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(M - 1);
  localparam logic [CW-1:0] MISM_MAX = '1;

  state_t        state_q, state_d;
  logic [M-1:0]  key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] mism_q, mism_d;
  logic          tx_en_q, tx_en_d;
  logic          rx_en_q, rx_en_d;

  logic shifting;
  logic accept;
  logic bit_bad;

  always_comb begin
    shifting  = (state_q == S_LOAD) || (state_q == S_VERIFY);
    key_ready = !shifting;
    accept    = key_valid && key_ready;

    cfg_en   = shifting;
    cfg_do   = shifting & key_q[M-1];
    busy     = shifting;
    key_ok   = (state_q == S_RUN);
    err      = (state_q == S_ERR);
    tx_en    = tx_en_q;
    rx_en    = rx_en_q;
    mism_cnt = mism_q;

    // The chain is M deep, so during VERIFY the returning bit must equal
    // the bit being sent again right now.
    bit_bad = (state_q == S_VERIFY) && (cfg_di != key_q[M-1]);

    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    mism_d  = mism_q;
    // Enables are only ever set while staying in RUN. This keeps them low in
    // every cycle in which cfg_en can be high.
    tx_en_d = 1'b0;
    rx_en_d = 1'b0;

    unique case (state_q)
      S_LOAD, S_VERIFY: begin
        // Rotate rather than shift: after M cycles the key register holds
        // the original key again, ready for the verify pass.
        key_d = {key_q[M-2:0], key_q[M-1]};
        cnt_d = cnt_q + 1'b1;
        if (bit_bad && (mism_q != MISM_MAX)) begin
          mism_d = mism_q + 1'b1;
        end
        if (cnt_q == LAST_BIT) begin
          cnt_d = '0;
          if (state_q == S_LOAD) begin
            state_d = S_VERIFY;
          end else begin
            // mism_d already includes the compare from this last cycle.
            state_d = (mism_d == '0) ? S_RUN : S_ERR;
          end
        end
      end
      S_RUN: begin
        tx_en_d = tx_req;
        rx_en_d = rx_req;
      end
      default: ;
    endcase

    if (accept) begin
      key_d   = key_data;
      cnt_d   = '0;
      mism_d  = '0;
      state_d = S_LOAD;
      tx_en_d = 1'b0;
      rx_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      mism_q  <= '0;
      tx_en_q <= 1'b0;
      rx_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      mism_q  <= mism_d;
      tx_en_q <= tx_en_d;
      rx_en_q <= rx_en_d;
    end
  end

endmodule
